// File: rtl/storage_arbiter_if.sv
// Client and storage-side signal bundle for storage_arbiter.
// master = clients plus RAM (testbench side), slave = arbiter.
interface storage_arbiter_if #(
   parameter int unsigned N_CLIENTS = 3,
   parameter int unsigned ADDR_W    = 9,
   parameter int unsigned DATA_W    = 32
);
   logic [N_CLIENTS-1:0]        i_req;
   logic [N_CLIENTS-1:0]        i_lock;
   logic [N_CLIENTS-1:0]        i_we;
   logic [N_CLIENTS*ADDR_W-1:0] i_addr;
   logic [N_CLIENTS*DATA_W-1:0] i_wdata;
   logic [N_CLIENTS-1:0]        o_gnt;
   logic [N_CLIENTS-1:0]        o_rvalid;
   logic [DATA_W-1:0]           o_rdata;
   logic                        o_mem_we;
   logic [ADDR_W-1:0]           o_mem_addr;
   logic [DATA_W-1:0]           o_mem_wdata;
   logic [DATA_W-1:0]           i_mem_rdata;
   logic                        o_preempt;

   modport master (
      output i_req, i_lock, i_we, i_addr, i_wdata, i_mem_rdata,
      input  o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata, o_preempt
   );

   modport slave (
      input  i_req, i_lock, i_we, i_addr, i_wdata, i_mem_rdata,
      output o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata, o_preempt
   );
endinterface

// File: rtl/storage_arbiter.sv
// Round-robin arbiter with burst lock and hold-limit preemption in front of
// the single-port matrix storage; read data is tagged back to the issuing client.
module storage_arbiter #(
   parameter int unsigned N_CLIENTS = 3,
   parameter int unsigned ADDR_W    = 9,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned MAX_HOLD  = 64
) (
   input logic              clk,
   input logic              rst_n,
   storage_arbiter_if.slave bus
);
   localparam int unsigned IDX_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
   localparam int unsigned SCAN_W = IDX_W + 1;
   localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {ST_IDLE, ST_OWNED} state_t;

   state_t               r_state, w_state_nxt;
   logic [IDX_W-1:0]     r_owner, w_owner_nxt;
   logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
   logic [HOLD_W-1:0]    r_hold, w_hold_nxt;
   logic [N_CLIENTS-1:0] r_gnt, w_gnt_nxt;
   logic [N_CLIENTS-1:0] r_tag [RD_LAT];

   logic                 w_owned, w_req_sel, w_lock_sel, w_we_sel, w_keep_req;
   logic                 w_other_req, w_preempt, w_access, w_rd, w_found;
   logic [N_CLIENTS-1:0] w_owner_oh;
   logic [ADDR_W-1:0]    w_addr;
   logic [DATA_W-1:0]    w_wdata;
   logic [IDX_W-1:0]     w_pick;
   logic [SCAN_W-1:0]    w_scan;

   // Select the registered owner's request fields.
   always_comb begin
      w_owner_oh = '0;
      w_req_sel  = 1'b0;
      w_lock_sel = 1'b0;
      w_we_sel   = 1'b0;
      w_addr     = '0;
      w_wdata    = '0;
      for (int k = 0; k < int'(N_CLIENTS); k++) begin
         if (r_owner == IDX_W'(k)) begin
            w_owner_oh[k] = 1'b1;
            w_req_sel     = bus.i_req[k];
            w_lock_sel    = bus.i_lock[k];
            w_we_sel      = bus.i_we[k];
            w_addr        = bus.i_addr[k*ADDR_W +: ADDR_W];
            w_wdata       = bus.i_wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   assign w_owned     = (r_state == ST_OWNED);
   assign w_keep_req  = w_req_sel | w_lock_sel;
   assign w_other_req = |(bus.i_req & ~w_owner_oh);
   assign w_preempt   = w_owned & ~w_lock_sel & (r_hold == HOLD_MAX) & w_other_req;
   assign w_access    = w_owned & w_req_sel;
   assign w_rd        = w_access & ~w_we_sel;

   // Next owner, pointer and hold counter.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_hold_nxt  = r_hold;
      w_gnt_nxt   = '0;
      w_found     = 1'b0;
      w_pick      = '0;
      w_scan      = '0;

      for (int i = 0; i < int'(N_CLIENTS); i++) begin
         w_scan = {1'b0, r_ptr} + SCAN_W'(i);
         if (w_scan >= SCAN_W'(N_CLIENTS)) w_scan = w_scan - SCAN_W'(N_CLIENTS);
         if (!w_found && bus.i_req[w_scan[IDX_W-1:0]] &&
             !(w_preempt && (w_scan[IDX_W-1:0] == r_owner))) begin
            w_found = 1'b1;
            w_pick  = w_scan[IDX_W-1:0];
         end
      end

      if (w_owned && w_keep_req && !w_preempt) begin
         if (!w_other_req)             w_hold_nxt = '0;
         else if (r_hold != HOLD_MAX)  w_hold_nxt = r_hold + HOLD_W'(1);
      end else begin
         if (w_owned)
            w_ptr_nxt = (r_owner == IDX_W'(N_CLIENTS - 1)) ? '0 : r_owner + IDX_W'(1);
         w_hold_nxt = '0;
         if (w_found) begin
            w_state_nxt = ST_OWNED;
            w_owner_nxt = w_pick;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end

      for (int k = 0; k < int'(N_CLIENTS); k++)
         w_gnt_nxt[k] = (w_state_nxt == ST_OWNED) && (w_owner_nxt == IDX_W'(k));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
         r_hold  <= '0;
         r_gnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_hold  <= w_hold_nxt;
         r_gnt   <= w_gnt_nxt;
      end
   end

   // Read tags follow the RAM latency so late data reaches the original client.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RD_LAT); i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= w_rd ? w_owner_oh : '0;
         for (int i = 1; i < int'(RD_LAT); i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign bus.o_gnt       = r_gnt;
   assign bus.o_rvalid    = r_tag[RD_LAT-1];
   assign bus.o_rdata     = bus.i_mem_rdata;
   assign bus.o_mem_we    = w_access & w_we_sel;
   assign bus.o_mem_addr  = w_access ? w_addr  : '0;
   assign bus.o_mem_wdata = w_access ? w_wdata : '0;
   assign bus.o_preempt   = w_preempt;
endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter: grant order, memory path, read tagging,
// hold-limit preemption, lock and asynchronous reset.
module tb_storage_arbiter;
   localparam int unsigned N  = 3;
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   storage_arbiter_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   storage_arbiter #(
      .N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_HOLD(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-cycle RAM model: address 0x010 returns DEADBEEF, others echo the address.
   logic [AW-1:0] a1, a2;
   always @(posedge clk) begin
      a1 <= bus.o_mem_addr;
      a2 <= a1;
   end
   assign bus.i_mem_rdata = (a2 == 9'h010) ? 32'hDEAD_BEEF : {23'h0, a2};

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      bus.i_req   = '0;
      bus.i_lock  = '0;
      bus.i_we    = '0;
      bus.i_addr  = '0;
      bus.i_wdata = '0;

      #12;
      chk("rst_gnt",       32'(bus.o_gnt),       32'h0);
      chk("rst_rvalid",    32'(bus.o_rvalid),    32'h0);
      chk("rst_preempt",   32'(bus.o_preempt),   32'h0);
      chk("rst_mem_we",    32'(bus.o_mem_we),    32'h0);
      chk("rst_mem_addr",  32'(bus.o_mem_addr),  32'h0);
      chk("rst_mem_wdata", bus.o_mem_wdata,      32'h0);
      rst_n = 1'b1;

      // Rotation: all request, each owner drops in turn.
      tick();
      bus.i_req = 3'b111;
      #1 chk("rr_idle", 32'(bus.o_gnt), 32'h0);
      tick();
      chk("rr_gnt0", 32'(bus.o_gnt), 32'b001);
      tick();
      bus.i_req = 3'b110;
      #1 chk("rr_gnt0_hold", 32'(bus.o_gnt), 32'b001);
      tick();
      chk("rr_gnt1", 32'(bus.o_gnt), 32'b010);
      bus.i_req = 3'b100;
      tick();
      chk("rr_gnt2", 32'(bus.o_gnt), 32'b100);
      chk("rr_no_preempt", 32'(bus.o_preempt), 32'h0);
      bus.i_req = 3'b000;
      tick();
      chk("rr_release_idle", 32'(bus.o_gnt), 32'h0);
      tick();
      tick();

      // Client 1 read of 0x010, then handover to client 0 writing 5 to 0x003.
      bus.i_req = 3'b010;
      bus.i_addr[AW +: AW] = 9'h010;
      #1 chk("rd_idle", 32'(bus.o_gnt), 32'h0);
      tick();
      chk("rd_gnt1",      32'(bus.o_gnt),      32'b010);
      chk("rd_addr",      32'(bus.o_mem_addr), 32'h010);
      chk("rd_we",        32'(bus.o_mem_we),   32'h0);
      chk("rd_rvalid_t0", 32'(bus.o_rvalid),   32'h0);
      tick();
      bus.i_req = 3'b001;
      bus.i_we  = 3'b011;
      bus.i_addr[0 +: AW]   = 9'h003;
      bus.i_wdata[0 +: DW]  = 32'h0000_0005;
      bus.i_addr[AW +: AW]  = 9'h1FF;
      bus.i_wdata[DW +: DW] = 32'hFFFF_FFFF;
      #1;
      chk("rd_rvalid_t1",  32'(bus.o_rvalid), 32'h0);
      chk("rd_drop_no_we", 32'(bus.o_mem_we), 32'h0);
      chk("rd_drop_gnt",   32'(bus.o_gnt),    32'b010);
      tick();
      chk("wr_gnt0",       32'(bus.o_gnt),       32'b001);
      chk("rd_rvalid_t2",  32'(bus.o_rvalid),    32'b010);
      chk("rd_rdata",      bus.o_rdata,          32'hDEAD_BEEF);
      chk("wr_we",         32'(bus.o_mem_we),    32'h1);
      chk("wr_addr",       32'(bus.o_mem_addr),  32'h003);
      chk("wr_wdata",      bus.o_mem_wdata,      32'h0000_0005);
      tick();
      bus.i_req = 3'b000;
      #1;
      chk("wr_no_rvalid",  32'(bus.o_rvalid),    32'h0);
      chk("noacc_we",      32'(bus.o_mem_we),    32'h0);
      chk("noacc_addr",    32'(bus.o_mem_addr),  32'h0);
      chk("noacc_wdata",   bus.o_mem_wdata,      32'h0);
      tick();
      chk("wr_release", 32'(bus.o_gnt), 32'h0);
      bus.i_we    = '0;
      bus.i_addr  = '0;
      bus.i_wdata = '0;

      // Hold limit: client 2 owns, client 0 waits, preempt on the 4th waiting cycle.
      bus.i_req = 3'b100;
      tick();
      chk("pre_gnt2", 32'(bus.o_gnt), 32'b100);
      bus.i_req = 3'b101;
      for (int i = 0; i < 4; i++) begin
         #1 chk("pre_pulse", 32'(bus.o_preempt), (i == 3) ? 32'h1 : 32'h0);
         chk("pre_gnt_held", 32'(bus.o_gnt), 32'b100);
         tick();
      end
      chk("pre_gnt0",      32'(bus.o_gnt),     32'b001);
      chk("pre_pulse_end", 32'(bus.o_preempt), 32'h0);
      bus.i_req = 3'b000;
      tick();
      chk("pre_release", 32'(bus.o_gnt), 32'h0);

      // Lock: lock-only owner makes no access and is never preempted.
      bus.i_req  = 3'b100;
      bus.i_lock = 3'b100;
      tick();
      chk("lk_gnt2", 32'(bus.o_gnt), 32'b100);
      bus.i_req = 3'b001;
      bus.i_we  = 3'b100;
      bus.i_addr[2*AW +: AW] = 9'h0AA;
      #1;
      chk("lk_only_we",   32'(bus.o_mem_we),   32'h0);
      chk("lk_only_addr", 32'(bus.o_mem_addr), 32'h0);
      tick();
      chk("lk_only_gnt", 32'(bus.o_gnt), 32'b100);
      bus.i_req = 3'b101;
      bus.i_we  = 3'b000;
      for (int i = 0; i < 100; i++) begin
         #1 chk("lk_no_preempt", 32'(bus.o_preempt), 32'h0);
         chk("lk_gnt_kept", 32'(bus.o_gnt), 32'b100);
         tick();
      end
      bus.i_req  = 3'b001;
      bus.i_lock = 3'b000;
      tick();
      chk("lk_handover", 32'(bus.o_gnt), 32'b001);
      bus.i_req  = 3'b000;
      bus.i_addr = '0;
      tick();
      tick();
      tick();

      // Asynchronous reset with two reads of client 2 in flight.
      bus.i_req = 3'b100;
      tick();
      chk("rs_gnt2", 32'(bus.o_gnt), 32'b100);
      tick();
      tick();
      chk("rs_rvalid_pre", 32'(bus.o_rvalid), 32'b100);
      rst_n = 1'b0;
      #1;
      chk("rs_gnt_clr",    32'(bus.o_gnt),      32'h0);
      chk("rs_rvalid_clr", 32'(bus.o_rvalid),   32'h0);
      chk("rs_addr_clr",   32'(bus.o_mem_addr), 32'h0);
      tick();
      chk("rs_rvalid_lost", 32'(bus.o_rvalid), 32'h0);
      bus.i_req = 3'b111;
      rst_n = 1'b1;
      #1 chk("rs_gnt_idle", 32'(bus.o_gnt), 32'h0);
      tick();
      chk("rs_ptr_zero", 32'(bus.o_gnt), 32'b001);
      bus.i_req = 3'b000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
